// File: rtl/uart_alu_frame_ctrl.sv
// rtl/uart_alu_frame_ctrl.sv - UART command-frame assembler, ALU operand/result sequencer and tx serialiser
module uart_alu_frame_ctrl #(
    parameter int DATA_BITS      = 8,
    parameter int OPND_BYTES     = 2,
    parameter int OPC_BITS       = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [DATA_BITS-1:0]            i_rx_data,
    input  logic                            i_rx_valid,
    output logic [DATA_BITS*OPND_BYTES-1:0] o_opnd_a,
    output logic [DATA_BITS*OPND_BYTES-1:0] o_opnd_b,
    output logic [OPC_BITS-1:0]             o_opcode,
    input  logic [DATA_BITS*OPND_BYTES-1:0] i_alu_result,
    output logic [DATA_BITS-1:0]            o_tx_data,
    output logic                            o_tx_start,
    input  logic                            i_tx_available,
    output logic                            o_busy,
    output logic                            o_frame_err,
    output logic                            o_overrun,
    output logic [2:0]                      o_state
);

    localparam int OPND_W = DATA_BITS * OPND_BYTES;
    localparam int CNT_W  = $clog2(OPND_BYTES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_RX_A    = 3'd0,
        S_RX_B    = 3'd1,
        S_RX_OP   = 3'd2,
        S_EXEC    = 3'd3,
        S_TX_WAIT = 3'd4,
        S_TX_BUSY = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    txcnt_q, txcnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [OPND_W-1:0]   opnd_a_q, opnd_a_d;
    logic [OPND_W-1:0]   opnd_b_q, opnd_b_d;
    logic [OPC_BITS-1:0] opc_q, opc_d;
    logic [OPND_W-1:0]   res_q, res_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;

    logic partial;
    logic expire;
    logic last_rx_byte;
    logic last_tx_byte;
    logic busy_state;

    assign busy_state   = (state_q == S_EXEC) || (state_q == S_TX_WAIT) || (state_q == S_TX_BUSY);
    // A frame is in progress once any byte of it has been taken in
    assign partial      = (state_q == S_RX_B) || (state_q == S_RX_OP) ||
                          ((state_q == S_RX_A) && (cnt_q != '0));
    // A byte landing on the expiry cycle wins over the timeout
    assign expire       = partial && !i_rx_valid && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_rx_byte = (cnt_q == CNT_W'(OPND_BYTES - 1));
    assign last_tx_byte = (txcnt_q == CNT_W'(OPND_BYTES - 1));

    // Inter-byte timeout counter: runs only while a frame is partial
    always_comb begin
        to_d = to_q + 1'b1;
        if (!partial || i_rx_valid || expire) begin
            to_d = '0;
        end
    end

    // Next-state, operand assembly, result capture and tx sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txcnt_d     = txcnt_q;
        opnd_a_d    = opnd_a_q;
        opnd_b_d    = opnd_b_q;
        opc_d       = opc_q;
        res_d       = res_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        case (state_q)
            S_RX_A, S_RX_B: begin
                if (i_rx_valid) begin
                    for (int i = 0; i < OPND_BYTES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            if (state_q == S_RX_A) begin
                                opnd_a_d[i*DATA_BITS +: DATA_BITS] = i_rx_data;
                            end else begin
                                opnd_b_d[i*DATA_BITS +: DATA_BITS] = i_rx_data;
                            end
                        end
                    end
                    if (last_rx_byte) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_RX_A) ? S_RX_B : S_RX_OP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (expire) begin
                    state_d     = S_RX_A;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end
            end
            S_RX_OP: begin
                if (i_rx_valid) begin
                    opc_d   = i_rx_data[OPC_BITS-1:0];
                    state_d = S_EXEC;
                end else if (expire) begin
                    state_d     = S_RX_A;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end
            end
            S_EXEC: begin
                res_d   = i_alu_result;
                txcnt_d = '0;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (i_tx_available) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = res_q[DATA_BITS-1:0];
                    state_d    = S_TX_BUSY;
                end
            end
            S_TX_BUSY: begin
                // tx_uart dropping available means it took the byte
                if (!i_tx_available) begin
                    res_d   = res_q >> DATA_BITS;
                    txcnt_d = txcnt_q + 1'b1;
                    state_d = last_tx_byte ? S_RX_A : S_TX_WAIT;
                end
            end
            default: begin
                state_d = S_RX_A;
                cnt_d   = '0;
            end
        endcase

        if (i_rx_valid && busy_state) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_RX_A;
            cnt_q       <= '0;
            txcnt_q     <= '0;
            to_q        <= '0;
            opnd_a_q    <= '0;
            opnd_b_q    <= '0;
            opc_q       <= '0;
            res_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txcnt_q     <= txcnt_d;
            to_q        <= to_d;
            opnd_a_q    <= opnd_a_d;
            opnd_b_q    <= opnd_b_d;
            opc_q       <= opc_d;
            res_q       <= res_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_opnd_a    = opnd_a_q;
    assign o_opnd_b    = opnd_b_q;
    assign o_opcode    = opc_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_state;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb/tb_uart_alu_frame_ctrl.sv - directed vector bench for uart_alu_frame_ctrl with an A+B ALU
module tb_uart_alu_frame_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] opnd_a, opnd_b, alu;
    logic [5:0]  opcode;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_avail = 1'b1;
    logic        busy, frame_err, overrun;
    logic [2:0]  state;

    uart_alu_frame_ctrl #(
        .DATA_BITS(8), .OPND_BYTES(2), .OPC_BITS(6), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_opnd_a(opnd_a), .o_opnd_b(opnd_b), .o_opcode(opcode), .i_alu_result(alu),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_available(tx_avail),
        .o_busy(busy), .o_frame_err(frame_err), .o_overrun(overrun), .o_state(state)
    );

    assign alu = opnd_a + opnd_b;

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // tx_uart model: goes unavailable for a few cycles after each start pulse
    logic       tx_en = 1'b1;
    int         tx_busy_cnt = 0;
    int         npulse = 0;
    logic [7:0] txq[$];

    always @(negedge clk) begin
        if (tx_start) begin
            tx_busy_cnt = 4;
            npulse++;
            txq.push_back(tx_data);
        end else if (tx_busy_cnt > 0) begin
            tx_busy_cnt--;
        end
        tx_avail = tx_en && (tx_busy_cnt == 0);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op;
        logic [5:0]  opc;
        logic [7:0]  t0;
        logic [7:0]  t1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        send_byte(a[7:0]);  tick();
        send_byte(a[15:8]); tick();
        send_byte(b[7:0]);  tick();
        send_byte(b[15:8]); tick();
        send_byte(op);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s);
        int n = 0;
        while (state !== s && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(state), 32'(s));
    endtask

    function automatic logic [7:0] get_tx(input int i);
        return (txq.size() > i) ? txq[i] : 8'hxx;
    endfunction

    task automatic check_tx(input string name, input int p0, input logic [7:0] t0, input logic [7:0] t1);
        check({name, "_pulses"}, 32'(npulse - p0), 32'd2);
        check({name, "_tx0"}, 32'(get_tx(0)), 32'(t0));
        check({name, "_tx1"}, 32'(get_tx(1)), 32'(t1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int bad_start;
        int bad_state;

        vecs[0] = '{16'h1234, 16'h0001, 8'h20, 6'h20, 8'h35, 8'h12};
        vecs[1] = '{16'hFFFF, 16'h0001, 8'h55, 6'h15, 8'h00, 8'h00};
        vecs[2] = '{16'h00FF, 16'h0001, 8'hE5, 6'h25, 8'h00, 8'h01};
        vecs[3] = '{16'hABCD, 16'h1111, 8'h3F, 6'h3F, 8'hDE, 8'hBC};
        vecs[4] = '{16'h0000, 16'h0000, 8'hC0, 6'h00, 8'h00, 8'h00};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        check("rst_state",    32'(state),     32'd0);
        check("rst_opnd_a",   32'(opnd_a),    32'd0);
        check("rst_opnd_b",   32'(opnd_b),    32'd0);
        check("rst_opcode",   32'(opcode),    32'd0);
        check("rst_tx_data",  32'(tx_data),   32'd0);
        check("rst_tx_start", 32'(tx_start),  32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_ferr",     32'(frame_err), 32'd0);
        check("rst_ovr",      32'(overrun),   32'd0);
        rst = 1'b0;
        tick();

        // Table-driven frames with first-pulse latency checks
        for (int i = 0; i < 5; i++) begin
            p0 = npulse;
            txq.delete();
            send_frame(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("v%0d_opnd_a", i), 32'(opnd_a), 32'(vecs[i].a));
            check($sformatf("v%0d_opnd_b", i), 32'(opnd_b), 32'(vecs[i].b));
            check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].opc));
            check($sformatf("v%0d_exec", i),   32'(state),  32'd3);
            check($sformatf("v%0d_busy", i),   32'(busy),   32'd1);
            tick();
            check($sformatf("v%0d_txwait", i), 32'(state),  32'd4);
            tick();
            check($sformatf("v%0d_start", i),  32'(tx_start), 32'd1);
            wait_state($sformatf("v%0d_done", i), 3'd0);
            check_tx($sformatf("v%0d", i), p0, vecs[i].t0, vecs[i].t1);
        end
        check("ferr_clean", 32'(frame_err), 32'd0);
        check("ovr_clean",  32'(overrun),   32'd0);

        // Byte strobe on the expiry cycle is accepted without error
        p0 = npulse;
        txq.delete();
        send_byte(8'h34);
        repeat (TO - 1) tick();
        send_byte(8'h12);
        check("simul_ferr", 32'(frame_err), 32'd0);
        check("simul_state", 32'(state), 32'd1);
        tick(); send_byte(8'h01); tick(); send_byte(8'h00); tick(); send_byte(8'h20);
        wait_state("simul_done", 3'd0);
        check_tx("simul", p0, 8'h35, 8'h12);

        // Timeout on a partial frame, then a fresh frame
        send_byte(8'h34);
        repeat (TO - 1) tick();
        check("to_before", 32'(frame_err), 32'd0);
        tick();
        check("to_ferr",  32'(frame_err), 32'd1);
        check("to_state", 32'(state),     32'd0);
        p0 = npulse;
        txq.delete();
        send_frame(16'h0010, 16'h0005, 8'h01);
        check("to_next_a", 32'(opnd_a), 32'h0010);
        wait_state("to_next_done", 3'd0);
        check_tx("to_next", p0, 8'h15, 8'h00);
        check("to_ferr_sticky", 32'(frame_err), 32'd1);

        // Backpressure: no start while tx is unavailable
        tx_en = 1'b0;
        p0 = npulse;
        txq.delete();
        bad_start = 0;
        bad_state = 0;
        send_frame(16'h0102, 16'h0304, 8'h02);
        tick();
        repeat (50) begin
            tick();
            if (tx_start !== 1'b0) bad_start++;
            if (state !== 3'd4) bad_state++;
        end
        check("bp_no_start", 32'(bad_start), 32'd0);
        check("bp_state4",   32'(bad_state), 32'd0);
        check("bp_pulses0",  32'(npulse - p0), 32'd0);
        tx_en = 1'b1;
        wait_state("bp_done", 3'd0);
        check_tx("bp", p0, 8'h06, 8'h04);

        // Overrun: byte injected while a tx byte is in flight
        p0 = npulse;
        txq.delete();
        send_frame(16'h1234, 16'h0001, 8'h20);
        wait_state("ovr_txbusy", 3'd5);
        send_byte(8'hAA);
        check("ovr_flag", 32'(overrun), 32'd1);
        wait_state("ovr_done", 3'd0);
        check_tx("ovr", p0, 8'h35, 8'h12);
        check("ovr_opnd_a", 32'(opnd_a), 32'h1234);
        check("ovr_opnd_b", 32'(opnd_b), 32'h0001);

        // Asynchronous reset between tx bytes
        p0 = npulse;
        txq.delete();
        send_frame(16'h1234, 16'h0001, 8'h20);
        begin
            int n = 0;
            while (!((npulse - p0) == 1 && state == 3'd4) && n < 300) begin
                tick();
                n++;
            end
            check("mid_wait", 32'(npulse - p0), 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        check("mid_state",   32'(state),     32'd0);
        check("mid_start",   32'(tx_start),  32'd0);
        check("mid_busy",    32'(busy),      32'd0);
        check("mid_opnd_a",  32'(opnd_a),    32'd0);
        check("mid_tx_data", 32'(tx_data),   32'd0);
        check("mid_ferr",    32'(frame_err), 32'd0);
        check("mid_ovr",     32'(overrun),   32'd0);
        repeat (3) tick();
        rst = 1'b0;
        p0 = npulse;
        repeat (20) tick();
        check("mid_no_pulse", 32'(npulse - p0), 32'd0);
        txq.delete();
        send_frame(16'hABCD, 16'h1111, 8'h3F);
        wait_state("mid_next_done", 3'd0);
        check_tx("mid_next", p0, 8'hDE, 8'hBC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
